// File: rtl/sdd_pkg.sv
// Shared types for the sort/dedup/delta stream: FSM states, sortable entry and its ordering rule.
package sdd_pkg;

  typedef enum logic [1:0] {LOAD, SORT, DEDUP, EMIT} state_t;

  localparam int unsigned SDD_MAX_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [SDD_MAX_W-1:0] data;
  } entry_t;

  // True when lo must move above hi: invalid entries sink past valid ones, ties stay put.
  function automatic logic sdd_out_of_order(entry_t lo, entry_t hi);
    return (hi.valid && !lo.valid) || (lo.valid && hi.valid && (lo.data > hi.data));
  endfunction

endpackage

// File: rtl/sdd_cmp_swap.sv
// One compare-exchange cell of the odd-even transposition network; passes through when disabled.
module sdd_cmp_swap
  import sdd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic            en_i,
  input  logic [DATA_W:0] a_i,
  input  logic [DATA_W:0] b_i,
  output logic [DATA_W:0] lo_o,
  output logic [DATA_W:0] hi_o
);

  entry_t a_e, b_e;
  logic   swap;

  assign a_e  = '{valid: a_i[DATA_W], data: SDD_MAX_W'(a_i[DATA_W-1:0])};
  assign b_e  = '{valid: b_i[DATA_W], data: SDD_MAX_W'(b_i[DATA_W-1:0])};
  assign swap = en_i && sdd_out_of_order(a_e, b_e);
  assign lo_o = swap ? b_i : a_i;
  assign hi_o = swap ? a_i : b_i;

endmodule

// File: rtl/sort_dedup_delta_stream.sv
// Frame sorter -> duplicate removal -> successive-difference encoder with valid/ready streams.
// Define SDD_DELTA_EN for delta-encoded output; otherwise sorted unique values are emitted raw.
module sort_dedup_delta_stream
  import sdd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 9,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [CNT_W-1:0]  unique_count,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  n_q, n_d, cnt_q, cnt_d, u_q, u_d, uc_q, uc_d, prev_idx;
  logic [DATA_W:0]   ent_q [DEPTH];
  logic [DATA_W:0]   ent_d [DEPTH];
  logic [DATA_W:0]   srt   [DEPTH];
  logic [DATA_W-1:0] uniq_q [DEPTH];
  logic [DATA_W-1:0] uniq_d [DEPTH];
  logic              ov_q, ov_d, ol_q, ol_d;
  logic [DATA_W-1:0] od_q, od_d, emit_word;
  logic [DATA_W:0]   lo_w [DEPTH-1];
  logic [DATA_W:0]   hi_w [DEPTH-1];
  logic [DEPTH-2:0]  cell_en;

  for (genvar i = 0; i < DEPTH - 1; i++) begin : g_cell
    assign cell_en[i] = (cnt_q[0] == 1'(i % 2));
    sdd_cmp_swap #(.DATA_W(DATA_W)) u_cs (
      .en_i (cell_en[i]),
      .a_i  (ent_q[i]),
      .b_i  (ent_q[i+1]),
      .lo_o (lo_w[i]),
      .hi_o (hi_w[i])
    );
  end

  always_comb begin
    srt = ent_q;
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      if (cell_en[i]) begin
        srt[i]   = lo_w[i];
        srt[i+1] = hi_w[i];
      end
    end
  end

  assign prev_idx = (cnt_q == '0) ? '0 : cnt_q - ONE;

`ifdef SDD_DELTA_EN
  assign emit_word = uniq_q[cnt_q] - uniq_q[prev_idx];
`else
  assign emit_word = uniq_q[cnt_q];
`endif

  assign in_ready     = (state_q == LOAD) && !rst;
  assign busy         = (state_q != LOAD);
  assign out_valid    = ov_q;
  assign out_data     = od_q;
  assign out_last     = ol_q;
  assign unique_count = uc_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    u_d     = u_q;
    uc_d    = uc_q;
    ent_d   = ent_q;
    uniq_d  = uniq_q;
    ov_d    = ov_q;
    od_d    = od_q;
    ol_d    = ol_q;
    case (state_q)
      LOAD: begin
        if (in_valid && in_ready) begin
          ent_d[n_q] = {1'b1, in_data};
          n_d        = n_q + ONE;
          if (in_last || n_q == LAST_IDX) begin
            state_d = SORT;
            cnt_d   = '0;
          end
        end
      end
      SORT: begin
        ent_d = srt;
        cnt_d = cnt_q + ONE;
        if (cnt_q == LAST_IDX) begin
          state_d = DEDUP;
          cnt_d   = '0;
          u_d     = '0;
        end
      end
      DEDUP: begin
        if (cnt_q == '0 || ent_q[cnt_q][DATA_W-1:0] != ent_q[prev_idx][DATA_W-1:0]) begin
          uniq_d[u_q] = ent_q[cnt_q][DATA_W-1:0];
          u_d         = u_q + ONE;
        end
        cnt_d = cnt_q + ONE;
        if (cnt_q == n_q - ONE) begin
          state_d = EMIT;
          cnt_d   = '0;
        end
      end
      EMIT: begin
        // out_valid only drops on the final handshake, so !ov_q here means the entry cycle.
        if (!ov_q) begin
          uc_d  = u_q;
          ov_d  = 1'b1;
          od_d  = uniq_q[0];
          ol_d  = (u_q == ONE);
          cnt_d = ONE;
        end else if (out_ready) begin
          if (ol_q) begin
            ov_d    = 1'b0;
            ol_d    = 1'b0;
            state_d = LOAD;
            n_d     = '0;
            for (int unsigned i = 0; i < DEPTH; i++) ent_d[i][DATA_W] = 1'b0;
          end else begin
            od_d  = emit_word;
            ol_d  = (cnt_q == u_q - ONE);
            cnt_d = cnt_q + ONE;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      n_q     <= '0;
      cnt_q   <= '0;
      u_q     <= '0;
      uc_q    <= '0;
      ent_q   <= '{default: '0};
      uniq_q  <= '{default: '0};
      ov_q    <= 1'b0;
      od_q    <= '0;
      ol_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      u_q     <= u_d;
      uc_q    <= uc_d;
      ent_q   <= ent_d;
      uniq_q  <= uniq_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
    end
  end

endmodule

// File: tb/tb_sort_dedup_delta_stream.sv
// Scoreboard bench: driver pushes reference-model expectations, a negedge monitor pops and compares.
module tb_sort_dedup_delta_stream;

  localparam int DEPTH  = 9;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [CNT_W-1:0]  unique_count;
  logic              busy;

  sort_dedup_delta_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .unique_count (unique_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       last;
    int         uc;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         rdy_mode = 0;
  logic [7:0] frame_w [DEPTH];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic last, input int uc);
    exp_t e;
    e.d = d; e.last = last; e.uc = uc;
    exp_q.push_back(e);
  endtask

  // Reference: sort the frame, keep distinct values, then emit first value and differences.
  task automatic push_model(input int len);
    int q[$];
    int u[$];
    logic [7:0] d;
    for (int i = 0; i < len; i++) q.push_back(int'(frame_w[i]));
    q.sort();
    foreach (q[i]) if (u.size() == 0 || u[u.size()-1] != q[i]) u.push_back(q[i]);
    foreach (u[j]) begin
`ifdef SDD_DELTA_EN
      d = (j == 0) ? 8'(u[0]) : 8'(u[j] - u[j-1]);
`else
      d = 8'(u[j]);
`endif
      push_exp(d, j == u.size() - 1, u.size());
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    logic       pv;
    logic [7:0] pd;
    logic       pl;
    exp_t       e;
    pv = 1'b0; pd = '0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv) begin
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_data", int'(out_data), int'(pd));
          chk("stall_last", int'(out_last), int'(pl));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out actual=%0d required=none t=%0t", out_data, $time);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", int'(out_data), int'(e.d));
            chk("out_last", int'(out_last), int'(e.last));
            chk("unique_count", int'(unique_count), e.uc);
            chk("in_ready_busy", int'(in_ready), 0);
          end
        end
        pv = out_valid && !out_ready;
        pd = out_data;
        pl = out_last;
      end
    end
  end

  task automatic drive_words(input int len, input logic use_last);
    int guard;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frame_w[i];
      in_last  = (i == len - 1) && use_last;
      guard = 0;
      while (!in_ready && guard < 3000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 3000) bound_fail("in_ready_wait");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  // Counts edges after the final accepted word; junk input during SORT must be ignored.
  task automatic check_latency(input int len);
    int edges;
    edges = 0;
    while (edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      if (out_valid) break;
      if (edges < DEPTH - 1) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("latency", edges, DEPTH + len + 1);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(exp_q.size() == 0 && in_ready) && guard < 3000);
    if (guard >= 3000) begin
      bound_fail("frame_done");
      exp_q.delete();
    end
  endtask

  task automatic send_frame(input int len, input logic use_last);
    drive_words(len, use_last);
    check_latency(len);
    wait_done();
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_unique_count"}, int'(unique_count), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_in_ready_rst"}, int'(in_ready), 0);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk({tag, "_in_ready_rel"}, int'(in_ready), 1);
  endtask

  task automatic push_case1();
`ifdef SDD_DELTA_EN
    push_exp(8'd1, 1'b0, 6); push_exp(8'd1, 1'b0, 6); push_exp(8'd1, 1'b0, 6);
    push_exp(8'd2, 1'b0, 6); push_exp(8'd2, 1'b0, 6); push_exp(8'd2, 1'b1, 6);
`else
    push_exp(8'd1, 1'b0, 6); push_exp(8'd2, 1'b0, 6); push_exp(8'd3, 1'b0, 6);
    push_exp(8'd5, 1'b0, 6); push_exp(8'd7, 1'b0, 6); push_exp(8'd9, 1'b1, 6);
`endif
  endtask

  initial begin
    int len;
    int guard;
    logic use_last;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_unique_count", int'(unique_count), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("rel_in_ready", int'(in_ready), 1);

    rdy_mode = 1;
    frame_w = '{8'd5, 8'd3, 8'd9, 8'd3, 8'd1, 8'd9, 8'd7, 8'd2, 8'd5};
    push_case1();
    send_frame(9, 1'b0);

    frame_w = '{default: 8'd4};
    push_exp(8'd4, 1'b1, 1);
    send_frame(9, 1'b0);

    frame_w = '{default: 8'd0};
    frame_w[0] = 8'd200; frame_w[1] = 8'd10;
`ifdef SDD_DELTA_EN
    push_exp(8'd10, 1'b0, 2); push_exp(8'd190, 1'b1, 2);
`else
    push_exp(8'd10, 1'b0, 2); push_exp(8'd200, 1'b1, 2);
`endif
    send_frame(2, 1'b1);

    frame_w[0] = 8'd255; frame_w[1] = 8'd0; frame_w[2] = 8'd0; frame_w[3] = 8'd255;
    push_exp(8'd0, 1'b0, 2); push_exp(8'd255, 1'b1, 2);
    send_frame(4, 1'b1);

    for (int f = 0; f < 100; f++) begin
      len = $urandom_range(1, DEPTH);
      for (int i = 0; i < DEPTH; i++)
        frame_w[i] = $urandom_range(0, 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      use_last = (len < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      push_model(len);
      send_frame(len, use_last);
    end

    frame_w = '{8'd5, 8'd3, 8'd9, 8'd3, 8'd1, 8'd9, 8'd7, 8'd2, 8'd5};
    drive_words(9, 1'b0);
    repeat (3) @(posedge clk);
    pulse_reset("sort_rst");

    rdy_mode = 2;
    drive_words(9, 1'b0);
    guard = 0;
    while (!out_valid && guard < 200) begin
      @(posedge clk);
      #1 guard++;
    end
    if (guard >= 200) bound_fail("emit_wait");
    chk("emit_unique_count", int'(unique_count), 6);
    pulse_reset("emit_rst");

    rdy_mode = 1;
    push_case1();
    send_frame(9, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
